fwrisc_trap_seq: RTL and testbench
==================================

Name: fwrisc_trap_seq

Overview:
- Trap/return sequencer that owns the register-file write port and RB read port while a trap or MRET is in progress.
- On a trap it writes MEPC, MCAUSE and MTVAL into the CSR slots of the register file over consecutive cycles. It then reads MTVEC and returns the handler PC.
- On MRET it reads MEPC and returns the resume PC.
- Sits between core decode/exec and the register file. Outside a sequence, core port traffic passes straight through.

Parameters:
- MEPC_IDX, 6'h29, regfile index of MEPC (must lie outside 6'h20-6'h27)
- MCAUSE_IDX, 6'h2A, regfile index of MCAUSE (must lie outside 6'h20-6'h27)
- MTVAL_IDX, 6'h2B, regfile index of MTVAL (must lie outside 6'h20-6'h27)
- MTVEC_IDX, 6'h25, RB-port index that returns mtvec

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- trap_req  in  1  single-cycle trap request pulse
- trap_cause  in  32  mcause value; bit31=interrupt
- trap_epc  in  32  faulting/interrupted PC
- trap_tval  in  32  mtval value
- mret_req  in  1  single-cycle MRET request pulse
- busy  out  1  sequence active; core must stall
- done  out  1  one-cycle pulse, target_pc valid
- target_pc  out  32  handler or resume PC
- req_drop  out  1  one-cycle pulse: request arrived while busy
- core_wr_drop  out  1  one-cycle pulse: core write blocked while busy
- core_rb_raddr  in  6  core RB address
- core_rd_waddr  in  6  core write address
- core_rd_wdata  in  32  core write data
- core_rd_wen  in  1  core write enable
- rf_rb_raddr  out  6  to regfile RB address
- rf_rd_waddr  out  6  to regfile write address
- rf_rd_wdata  out  32  to regfile write data
- rf_rd_wen  out  1  to regfile write enable
- rf_rb_rdata  in  32  regfile RB data (registered, 1-cycle latency)

Behaviour:
- Reset (reset low, async):
  - state=IDLE.
  - busy, done, req_drop, core_wr_drop = 0.
  - target_pc = 0.
  - Capture registers = 0.
  - Reset mid-sequence aborts immediately. CSR writes already issued remain in the regfile. No done is generated.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, RD, CAP.
- busy is registered: 1 in every state except IDLE.
- IDLE:
  - rf_* ports = core_* ports, combinational passthrough.
  - trap_req=1: latch cause/epc/tval and mode=TRAP, go to W_EPC.
  - Else mret_req=1: mode=MRET, go to RD.
  - trap_req has priority over a simultaneous mret_req. The mret is discarded and req_drop pulses.
  - A core write in the request cycle passes through (retiring instruction).
- W_EPC: rf_rd_wen=1, rf_rd_waddr=MEPC_IDX, rf_rd_wdata=epc_r. Next state W_CAUSE.
- W_CAUSE: rf_rd_wen=1, rf_rd_waddr=MCAUSE_IDX, rf_rd_wdata=cause_r. Next state W_TVAL.
- W_TVAL: rf_rd_wen=1, rf_rd_waddr=MTVAL_IDX, rf_rd_wdata=tval_r. Next state RD.
- RD:
  - rf_rb_raddr = MTVEC_IDX if mode=TRAP, else MEPC_IDX.
  - rf_rd_wen=0. Next state CAP.
- CAP (rf_rb_rdata now valid):
  - TRAP with rf_rb_rdata[1:0]=2'b01 and cause_r[31]=1: target_pc = {rdata[31:2],2'b00} + {cause_r[4:0],2'b00}, 32-bit, wrap-around ignored.
  - Other TRAP: target_pc = {rdata[31:2],2'b00}.
  - MRET: target_pc = {rdata[31:1],1'b0}.
  - done=1 for this cycle, registered so it is asserted with target_pc. Next state IDLE.
- target_pc holds its value until the next CAP.
- Latency:
  - Trap: request cycle to done = 5 cycles.
  - MRET: request cycle to done = 2 cycles.
  - A new request is accepted in the cycle after done.
- While busy:
  - trap_req/mret_req are ignored; req_drop pulses the next cycle.
  - core_rd_wen=1 is blocked (never reaches rf_rd_wen); core_wr_drop pulses the next cycle.
  - core_rb_raddr is ignored; rf_rb_raddr = MTVEC_IDX/MEPC_IDX in RD, core value otherwise.
- rf_rd_wen is never asserted by the sequencer outside W_EPC/W_CAUSE/W_TVAL.

Test Plan:
- Reset low mid-W_CAUSE → next cycle busy=0, state IDLE, done never pulses, MEPC slot holds written epc, MCAUSE unchanged.
- mtvec=32'h0000_0100; trap_req with cause=2, epc=32'h0000_0040, tval=32'hDEAD_BEEF → writes to 6'h29/6'h2A/6'h2B on cycles +1..+3; done at +5 with target_pc=32'h0000_0100.
- mtvec=32'h0000_0101, cause=32'h8000_0007 → target_pc=32'h0000_011C.
- MEPC=32'h0000_0083, mret_req → done 2 cycles later, target_pc=32'h0000_0082, no rf_rd_wen during sequence.
- trap_req and mret_req same cycle → trap sequence runs, req_drop pulses once. Second trap_req during W_TVAL → req_drop pulse, no second sequence.
- core_rd_wen=1 to x5 during W_EPC → rf_rd_wen carries only the MEPC write, core_wr_drop pulses, x5 unchanged. Same write in IDLE → passes through same cycle.

Source files
------------

// File: rtl/fwrisc_trap_seq.sv
// Purpose : trap/MRET sequencer; owns the regfile write port and RB read port while a sequence runs.
// Latency : trap request -> done in 5 cycles, MRET request -> done in 2 cycles; idle traffic is combinational.
// Backpr. : none; busy stalls the core, and dropped requests/writes are flagged one cycle later.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_trap_req/i_trap_cause/i_trap_epc/i_trap_tval : trap request and its CSR payload
//   i_mret_req                                      : return-from-trap request
//   o_busy, o_done, o_target_pc                     : sequence status and handler/resume PC
//   o_req_drop, o_core_wr_drop                      : one-cycle flags for requests/writes ignored while busy
//   i_core_*  -> o_rf_*                             : core regfile traffic, muxed with sequencer traffic
//   i_rf_rb_rdata                                   : regfile RB data, one cycle after the address
module fwrisc_trap_seq #(
    parameter logic [5:0] MEPC_IDX   = 6'h29,
    parameter logic [5:0] MCAUSE_IDX = 6'h2A,
    parameter logic [5:0] MTVAL_IDX  = 6'h2B,
    parameter logic [5:0] MTVEC_IDX  = 6'h25
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_trap_req,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_epc,
    input  logic [31:0] i_trap_tval,
    input  logic        i_mret_req,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_target_pc,
    output logic        o_req_drop,
    output logic        o_core_wr_drop,
    input  logic [5:0]  i_core_rb_raddr,
    input  logic [5:0]  i_core_rd_waddr,
    input  logic [31:0] i_core_rd_wdata,
    input  logic        i_core_rd_wen,
    output logic [5:0]  o_rf_rb_raddr,
    output logic [5:0]  o_rf_rd_waddr,
    output logic [31:0] o_rf_rd_wdata,
    output logic        o_rf_rd_wen,
    input  logic [31:0] i_rf_rb_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_TVAL  = 3'd3,
        RD      = 3'd4,
        CAP     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mode_trap;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_target_pc;
    logic        r_busy;
    logic        r_done;
    logic        r_req_drop;
    logic        r_core_wr_drop;

    logic        w_idle;
    logic        w_vectored;
    logic [31:0] w_trap_base;
    logic [31:0] w_target;

    assign w_idle = (r_state == IDLE);

    // Vectored mode (mtvec[1:0]=01) only offsets interrupts; exceptions go to the base.
    assign w_vectored  = r_mode_trap && (i_rf_rb_rdata[1:0] == 2'b01) && r_cause[31];
    assign w_trap_base = {i_rf_rb_rdata[31:2], 2'b00};
    assign w_target    = !r_mode_trap ? {i_rf_rb_rdata[31:1], 1'b0} :
                         w_vectored   ? (w_trap_base + {25'd0, r_cause[4:0], 2'b00}) :
                                        w_trap_base;

    // Read data only arrives in CAP, so the PC is shown combinationally there
    // and held from the register afterwards.
    assign o_target_pc    = (r_state == CAP) ? w_target : r_target_pc;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_req_drop     = r_req_drop;
    assign o_core_wr_drop = r_core_wr_drop;

    // Next state and regfile port mux. Address/data follow the core by
    // default; only the write enable is gated while a sequence owns the port.
    always_comb begin
        w_next        = r_state;
        o_rf_rb_raddr = i_core_rb_raddr;
        o_rf_rd_waddr = i_core_rd_waddr;
        o_rf_rd_wdata = i_core_rd_wdata;
        o_rf_rd_wen   = 1'b0;
        case (r_state)
            IDLE: begin
                o_rf_rd_wen = i_core_rd_wen;
                if (i_trap_req) begin
                    w_next = W_EPC;
                end else if (i_mret_req) begin
                    w_next = RD;
                end
            end
            W_EPC: begin
                o_rf_rd_wen   = 1'b1;
                o_rf_rd_waddr = MEPC_IDX;
                o_rf_rd_wdata = r_epc;
                w_next        = W_CAUSE;
            end
            W_CAUSE: begin
                o_rf_rd_wen   = 1'b1;
                o_rf_rd_waddr = MCAUSE_IDX;
                o_rf_rd_wdata = r_cause;
                w_next        = W_TVAL;
            end
            W_TVAL: begin
                o_rf_rd_wen   = 1'b1;
                o_rf_rd_waddr = MTVAL_IDX;
                o_rf_rd_wdata = r_tval;
                w_next        = RD;
            end
            RD: begin
                o_rf_rb_raddr = r_mode_trap ? MTVEC_IDX : MEPC_IDX;
                w_next        = CAP;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_mode_trap    <= 1'b0;
            r_cause        <= '0;
            r_epc          <= '0;
            r_tval         <= '0;
            r_target_pc    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_req_drop     <= 1'b0;
            r_core_wr_drop <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == CAP);
            if (w_idle && i_trap_req) begin
                r_mode_trap <= 1'b1;
                r_cause     <= i_trap_cause;
                r_epc       <= i_trap_epc;
                r_tval      <= i_trap_tval;
            end else if (w_idle && i_mret_req) begin
                r_mode_trap <= 1'b0;
            end
            if (r_state == CAP) begin
                r_target_pc <= w_target;
            end
            // In IDLE only the losing MRET of a simultaneous pair is dropped.
            r_req_drop     <= w_idle ? (i_trap_req & i_mret_req) : (i_trap_req | i_mret_req);
            r_core_wr_drop <= ~w_idle & i_core_rd_wen;
        end
    end

endmodule

// File: tb/tb_fwrisc_trap_seq.sv
module tb_fwrisc_trap_seq;

    localparam logic [5:0] MEPC   = 6'h29;
    localparam logic [5:0] MCAUSE = 6'h2A;
    localparam logic [5:0] MTVAL  = 6'h2B;
    localparam logic [5:0] MTVEC  = 6'h25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_epc = '0;
    logic [31:0] trap_tval = '0;
    logic        mret_req = 1'b0;
    logic        busy, done, req_drop, core_wr_drop;
    logic [31:0] target_pc;
    logic [5:0]  core_rb_raddr = '0;
    logic [5:0]  core_rd_waddr = '0;
    logic [31:0] core_rd_wdata = '0;
    logic        core_rd_wen = 1'b0;
    logic [5:0]  rf_rb_raddr, rf_rd_waddr;
    logic [31:0] rf_rd_wdata;
    logic        rf_rd_wen;
    logic [31:0] rf_rb_rdata = '0;

    logic        poke_en = 1'b0;
    logic [5:0]  poke_addr = '0;
    logic [31:0] poke_dat = '0;
    logic [31:0] regs [64];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwrisc_trap_seq dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_trap_req(trap_req), .i_trap_cause(trap_cause), .i_trap_epc(trap_epc),
        .i_trap_tval(trap_tval), .i_mret_req(mret_req),
        .o_busy(busy), .o_done(done), .o_target_pc(target_pc),
        .o_req_drop(req_drop), .o_core_wr_drop(core_wr_drop),
        .i_core_rb_raddr(core_rb_raddr), .i_core_rd_waddr(core_rd_waddr),
        .i_core_rd_wdata(core_rd_wdata), .i_core_rd_wen(core_rd_wen),
        .o_rf_rb_raddr(rf_rb_raddr), .o_rf_rd_waddr(rf_rd_waddr),
        .o_rf_rd_wdata(rf_rd_wdata), .o_rf_rd_wen(rf_rd_wen),
        .i_rf_rb_rdata(rf_rb_rdata)
    );

    // Register file model: synchronous write, registered RB read, plus a backdoor write.
    always @(posedge clk) begin
        if (rf_rd_wen) regs[rf_rd_waddr] <= rf_rd_wdata;
        if (poke_en) regs[poke_addr] <= poke_dat;
        rf_rb_rdata <= regs[rf_rb_raddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_dat = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Handler / resume PC from the architectural rules.
    function automatic logic [31:0] ref_pc(input bit is_trap, input logic [31:0] vec,
                                           input logic [31:0] cause);
        logic [31:0] base;
        if (!is_trap) return vec & ~32'd1;
        base = vec & ~32'd3;
        if ((vec % 4) == 1 && cause[31]) return base + 4 * (cause % 32);
        return base;
    endfunction

    typedef struct {
        bit          is_trap;
        logic [31:0] vec;      // mtvec for traps, MEPC for mret
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] exp_pc;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    // Random-phase model state
    int          done_cyc = -1;
    int          req_cyc = -10;
    bit          m_trap = 1'b0;
    logic [31:0] m_epc, m_cause, m_tval, m_pc, held_pc;
    logic [31:0] mtvec_sh, mepc_sh;
    bit          drop_prev = 1'b0, wdrop_prev = 1'b0;

    initial begin : main
        int lat, wen_cnt, drop_cnt, done_cnt;
        logic [31:0] pc_seen;

        tbl[0] = '{1'b1, 32'h0000_0100, 32'h0000_0002, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0100, 5};
        tbl[1] = '{1'b1, 32'h0000_0101, 32'h8000_0007, 32'h0000_0044, 32'h0000_0000, 32'h0000_011C, 5};
        tbl[2] = '{1'b0, 32'h0000_0083, 32'h0,         32'h0,         32'h0,         32'h0000_0082, 2};
        tbl[3] = '{1'b1, 32'h0000_0101, 32'h0000_0007, 32'h0000_1000, 32'h0000_0011, 32'h0000_0100, 5};
        tbl[4] = '{1'b1, 32'h0000_0103, 32'h8000_0003, 32'h0000_2000, 32'h0000_0022, 32'h0000_0100, 5};
        tbl[5] = '{1'b1, 32'hFFFF_FFFD, 32'h8000_001F, 32'h0000_3000, 32'h0000_0033, 32'h0000_0078, 5};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFE, 2};

        // Reset state and idle passthrough
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req_drop", {31'd0, req_drop}, 32'd0);
        chk("rst_wr_drop", {31'd0, core_wr_drop}, 32'd0);
        chk("rst_target_pc", target_pc, 32'd0);
        rst_n = 1'b1;
        tick();
        core_rb_raddr = 6'h07; core_rd_waddr = 6'h03; core_rd_wdata = 32'hCAFE_0003; core_rd_wen = 1'b1;
        #1;
        chk("pass_raddr", {26'd0, rf_rb_raddr}, 32'h07);
        chk("pass_waddr", {26'd0, rf_rd_waddr}, 32'h03);
        chk("pass_wdata", rf_rd_wdata, 32'hCAFE_0003);
        chk("pass_wen", {31'd0, rf_rd_wen}, 32'd1);
        tick();
        core_rd_wen = 1'b0;

        // Table-driven trap / mret sequences
        for (int i = 0; i < 7; i++) begin
            poke(tbl[i].is_trap ? MTVEC : MEPC, tbl[i].vec);
            trap_req = tbl[i].is_trap; mret_req = !tbl[i].is_trap;
            trap_cause = tbl[i].cause; trap_epc = tbl[i].epc; trap_tval = tbl[i].tval;
            lat = -1; wen_cnt = 0; pc_seen = '0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                trap_req = 1'b0; mret_req = 1'b0;
                @(negedge clk);
                if (rf_rd_wen) wen_cnt++;
                if (done && lat < 0) begin lat = k; pc_seen = target_pc; end
            end
            tick();
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_pc", i), pc_seen, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_pc_held", i), target_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_wen_cnt", i), wen_cnt, tbl[i].is_trap ? 3 : 0);
            chk($sformatf("tbl%0d_busy_after", i), {31'd0, busy}, 32'd0);
            if (tbl[i].is_trap) begin
                chk($sformatf("tbl%0d_mepc", i), regs[MEPC], tbl[i].epc);
                chk($sformatf("tbl%0d_mcause", i), regs[MCAUSE], tbl[i].cause);
                chk($sformatf("tbl%0d_mtval", i), regs[MTVAL], tbl[i].tval);
            end else begin
                chk($sformatf("tbl%0d_mepc_kept", i), regs[MEPC], tbl[i].vec);
            end
        end

        // Reset in the middle of W_CAUSE
        poke(MEPC, 32'h1111_1111);
        poke(MCAUSE, 32'h2222_2222);
        trap_req = 1'b1; trap_epc = 32'hABCD_0000; trap_cause = 32'h5; trap_tval = 32'h0;
        tick(); trap_req = 1'b0;
        tick();
        @(negedge clk);
        chk("rstmid_wcause_addr", {26'd0, rf_rd_waddr}, {26'd0, MCAUSE});
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_busy_now", {31'd0, busy}, 32'd0);
        chk("rstmid_wen_now", {31'd0, rf_rd_wen}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rstmid_busy_next", {31'd0, busy}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            tick();
        end
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_mepc", regs[MEPC], 32'hABCD_0000);
        chk("rstmid_mcause", regs[MCAUSE], 32'h2222_2222);
        chk("rstmid_pc", target_pc, 32'd0);

        // Simultaneous trap and mret
        poke(MTVEC, 32'h0000_0400);
        trap_req = 1'b1; mret_req = 1'b1; trap_epc = 32'h1234_5670; trap_cause = 32'h3;
        drop_cnt = 0; done_cnt = 0; pc_seen = '0;
        for (int k = 1; k <= 8; k++) begin
            tick(); trap_req = 1'b0; mret_req = 1'b0;
            @(negedge clk);
            if (req_drop) drop_cnt++;
            if (done) begin done_cnt++; pc_seen = target_pc; end
        end
        tick();
        chk("simul_drop_cnt", drop_cnt, 1);
        chk("simul_done_cnt", done_cnt, 1);
        chk("simul_pc", pc_seen, 32'h0000_0400);
        chk("simul_mepc", regs[MEPC], 32'h1234_5670);

        // Second trap during W_TVAL
        trap_req = 1'b1; trap_epc = 32'h0000_0500; trap_cause = 32'h4;
        drop_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            trap_req = (k == 3); trap_epc = (k == 3) ? 32'h0000_0900 : 32'h0000_0500;
            @(negedge clk);
            if (req_drop) drop_cnt++;
            if (done) done_cnt++;
        end
        tick();
        trap_req = 1'b0;
        chk("tval_drop_cnt", drop_cnt, 1);
        chk("tval_done_cnt", done_cnt, 1);
        chk("tval_mepc", regs[MEPC], 32'h0000_0500);

        // Core write to x5 during W_EPC is blocked; same write in IDLE passes
        poke(6'd5, 32'h0000_0055);
        trap_req = 1'b1; trap_epc = 32'h0000_0200; trap_cause = 32'h1;
        tick();
        trap_req = 1'b0;
        core_rd_wen = 1'b1; core_rd_waddr = 6'd5; core_rd_wdata = 32'h0000_0999;
        @(negedge clk);
        chk("blk_wen", {31'd0, rf_rd_wen}, 32'd1);
        chk("blk_waddr", {26'd0, rf_rd_waddr}, {26'd0, MEPC});
        chk("blk_wdata", rf_rd_wdata, 32'h0000_0200);
        tick();
        core_rd_wen = 1'b0;
        @(negedge clk);
        chk("blk_wr_drop", {31'd0, core_wr_drop}, 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("blk_x5_kept", regs[5], 32'h0000_0055);
        core_rd_wen = 1'b1; core_rd_waddr = 6'd5; core_rd_wdata = 32'h0000_0777;
        #1;
        chk("idle_wen", {31'd0, rf_rd_wen}, 32'd1);
        chk("idle_waddr", {26'd0, rf_rd_waddr}, 32'd5);
        tick();
        core_rd_wen = 1'b0;
        chk("idle_x5", regs[5], 32'h0000_0777);
        chk("idle_no_drop", {31'd0, core_wr_drop}, 32'd0);

        // Randomized run against the reference model
        mtvec_sh = $urandom; poke(MTVEC, mtvec_sh);
        mepc_sh = 32'h0000_1003; poke(MEPC, mepc_sh);
        tick();
        held_pc = target_pc;
        chk("rnd_start_idle", {31'd0, busy}, 32'd0);
        for (int t = 0; t < 600; t++) begin
            bit idle;
            logic [5:0] exp_ra;
            idle = (t > done_cyc);
            trap_req = ($urandom % 6) == 0;
            mret_req = ($urandom % 6) == 0;
            trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
            core_rd_wen = $urandom % 2;
            core_rd_waddr = 6'($urandom % 32);
            core_rd_wdata = $urandom;
            core_rb_raddr = 6'($urandom % 64);
            poke_en = 1'b0;
            if (idle && !trap_req && !mret_req && ($urandom % 8) == 0) begin
                mtvec_sh = $urandom;
                if ($urandom % 2) mtvec_sh[1:0] = 2'b01;
                poke_en = 1'b1; poke_addr = MTVEC; poke_dat = mtvec_sh;
            end
            @(negedge clk);
            chk("rnd_busy", {31'd0, busy}, {31'd0, !idle});
            chk("rnd_done", {31'd0, done}, {31'd0, t == done_cyc});
            chk("rnd_pc", target_pc, (t == done_cyc) ? m_pc : held_pc);
            chk("rnd_req_drop", {31'd0, req_drop}, {31'd0, drop_prev});
            chk("rnd_wr_drop", {31'd0, core_wr_drop}, {31'd0, wdrop_prev});
            exp_ra = (!idle && t == done_cyc - 1) ? (m_trap ? MTVEC : MEPC) : core_rb_raddr;
            chk("rnd_rb_raddr", {26'd0, rf_rb_raddr}, {26'd0, exp_ra});
            if (!idle && m_trap && (t - req_cyc) >= 1 && (t - req_cyc) <= 3) begin
                chk("rnd_csr_wen", {31'd0, rf_rd_wen}, 32'd1);
                case (t - req_cyc)
                    1: begin chk("rnd_csr_addr", {26'd0, rf_rd_waddr}, {26'd0, MEPC});   chk("rnd_csr_data", rf_rd_wdata, m_epc);   end
                    2: begin chk("rnd_csr_addr", {26'd0, rf_rd_waddr}, {26'd0, MCAUSE}); chk("rnd_csr_data", rf_rd_wdata, m_cause); end
                    default: begin chk("rnd_csr_addr", {26'd0, rf_rd_waddr}, {26'd0, MTVAL}); chk("rnd_csr_data", rf_rd_wdata, m_tval); end
                endcase
            end else if (idle) begin
                chk("rnd_core_wen", {31'd0, rf_rd_wen}, {31'd0, core_rd_wen});
                if (core_rd_wen) chk("rnd_core_addr", {26'd0, rf_rd_waddr}, {26'd0, core_rd_waddr});
            end else begin
                chk("rnd_busy_wen", {31'd0, rf_rd_wen}, 32'd0);
            end
            if (t == done_cyc) held_pc = m_pc;
            drop_prev  = idle ? (trap_req && mret_req) : (trap_req || mret_req);
            wdrop_prev = !idle && core_rd_wen;
            if (idle && trap_req) begin
                req_cyc = t; done_cyc = t + 5; m_trap = 1'b1;
                m_epc = trap_epc; m_cause = trap_cause; m_tval = trap_tval;
                m_pc = ref_pc(1'b1, mtvec_sh, trap_cause);
                mepc_sh = trap_epc;
            end else if (idle && mret_req) begin
                req_cyc = t; done_cyc = t + 2; m_trap = 1'b0;
                m_pc = ref_pc(1'b0, mepc_sh, 32'd0);
            end
            tick();
        end
        poke_en = 1'b0; trap_req = 1'b0; mret_req = 1'b0; core_rd_wen = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
